// File: rtl/mobius_pkg.sv
// Shared types and sizing helpers for the binary Mobius transform engine.
// The optional popcount output is enabled by defining MOBIUS_WEIGHT_EN.
package mobius_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // The round counter must be able to hold LOG2_N itself.
    function automatic int cnt_width(input int log2n);
        return $clog2(log2n + 1);
    endfunction

    function automatic int weight_width(input int log2n);
        return log2n + 1;
    endfunction

endpackage

// File: rtl/mobius_round.sv
// One Mobius round: butterfly on the upper half, then a perfect shuffle.
// Purely combinational; chained RPC times inside mobius_engine.
module mobius_round #(
    parameter int N = 512
) (
    input  logic [0:N-1] x,
    output logic [0:N-1] y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N / 2; i++) begin
            y[2*i]   = x[i];
            y[2*i+1] = x[i + N/2] ^ x[i];
        end
    end

endmodule

// File: rtl/mobius_engine.sv
// Handshaked binary Mobius transform (ANF <-> truth table) with RPC rounds per clock.
// Define MOBIUS_WEIGHT_EN to add the out_weight popcount port.
module mobius_engine
    import mobius_pkg::*;
#(
    parameter int LOG2_N = 9,
    parameter int RPC    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:(1<<LOG2_N)-1]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [0:(1<<LOG2_N)-1]    out_data
`ifdef MOBIUS_WEIGHT_EN
    ,
    output logic [weight_width(LOG2_N)-1:0] out_weight
`endif
);

    localparam int N  = 1 << LOG2_N;
    localparam int CW = cnt_width(LOG2_N);
    localparam logic [CW-1:0] RPC_C    = CW'(RPC);
    localparam logic [CW-1:0] LAST_CNT = CW'(LOG2_N - RPC);

    generate
        if (LOG2_N < 1 || RPC < 1 || RPC > LOG2_N || (LOG2_N % RPC) != 0) begin : g_bad_cfg
            $error("mobius_engine: RPC must satisfy 1 <= RPC <= LOG2_N and divide LOG2_N");
        end
    endgenerate

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [0:N-1]    data_reg;
    logic [0:N-1]    stage [RPC+1];

    assign stage[0] = data_reg;

    generate
        for (genvar g = 0; g < RPC; g++) begin : g_round
            mobius_round #(.N(N)) u_round (
                .x (stage[g]),
                .y (stage[g+1])
            );
        end
    endgenerate

    // Handshake outputs depend only on the state register, never on in_valid/out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign out_data  = data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            data_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= in_data;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    data_reg <= stage[RPC];
                    cnt      <= cnt + RPC_C;
                    if (cnt == LAST_CNT) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MOBIUS_WEIGHT_EN
    localparam int WW = weight_width(LOG2_N);

    always_comb begin
        out_weight = '0;
        for (int i = 0; i < N; i++) begin
            out_weight = out_weight + WW'(data_reg[i]);
        end
    end
`endif

endmodule

// File: tb/tb_mobius_engine.sv
// Self-checking bench for mobius_engine across several LOG2_N/RPC configurations.
// Honours MOBIUS_WEIGHT_EN when the design is built with the popcount port.
module tb_mobius_engine;

    typedef struct {
        int           inst;
        logic [0:511] din;
        logic [0:511] dexp;
        int           wexp;
    } vec_t;

    localparam int NI = 5;
    int log2n_of [NI] = '{3, 3, 9, 9, 9};
    int rpc_of   [NI] = '{1, 3, 1, 3, 9};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [NI];
    logic         out_ready [NI];
    logic [0:511] in_data   [NI];
    logic         rdy [NI];
    logic         vld [NI];
    logic [0:7]   od0, od1;
    logic [0:511] od2, od3, od4;
`ifdef MOBIUS_WEIGHT_EN
    logic [3:0]   w0, w1;
    logic [9:0]   w2, w3, w4;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mobius_engine #(.LOG2_N(3), .RPC(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy[0]),
        .in_data(in_data[0][0:7]), .out_valid(vld[0]), .out_ready(out_ready[0]), .out_data(od0)
`ifdef MOBIUS_WEIGHT_EN
        , .out_weight(w0)
`endif
    );
    mobius_engine #(.LOG2_N(3), .RPC(3)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy[1]),
        .in_data(in_data[1][0:7]), .out_valid(vld[1]), .out_ready(out_ready[1]), .out_data(od1)
`ifdef MOBIUS_WEIGHT_EN
        , .out_weight(w1)
`endif
    );
    mobius_engine #(.LOG2_N(9), .RPC(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy[2]),
        .in_data(in_data[2]), .out_valid(vld[2]), .out_ready(out_ready[2]), .out_data(od2)
`ifdef MOBIUS_WEIGHT_EN
        , .out_weight(w2)
`endif
    );
    mobius_engine #(.LOG2_N(9), .RPC(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(rdy[3]),
        .in_data(in_data[3]), .out_valid(vld[3]), .out_ready(out_ready[3]), .out_data(od3)
`ifdef MOBIUS_WEIGHT_EN
        , .out_weight(w3)
`endif
    );
    mobius_engine #(.LOG2_N(9), .RPC(9)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[4]), .in_ready(rdy[4]),
        .in_data(in_data[4]), .out_valid(vld[4]), .out_ready(out_ready[4]), .out_data(od4)
`ifdef MOBIUS_WEIGHT_EN
        , .out_weight(w4)
`endif
    );

    function automatic logic [0:511] out_of(input int k);
        case (k)
            0:       return {od0, 504'b0};
            1:       return {od1, 504'b0};
            2:       return od2;
            3:       return od3;
            default: return od4;
        endcase
    endfunction

`ifdef MOBIUS_WEIGHT_EN
    function automatic int weight_of(input int k);
        case (k)
            0:       return int'(w0);
            1:       return int'(w1);
            2:       return int'(w2);
            3:       return int'(w3);
            default: return int'(w4);
        endcase
    endfunction
`endif

    // Subset-sum transform done bit by bit in place: y[u] = XOR of x[v] for all v within u.
    function automatic logic [0:511] mobius_ref(input logic [0:511] x, input int log2n);
        logic [0:511] r;
        int n;
        r = x;
        n = 1 << log2n;
        for (int b = 0; b < log2n; b++)
            for (int i = 0; i < n; i++)
                if (((i >> b) & 1) == 1)
                    r[i] = r[i] ^ r[i ^ (1 << b)];
        return r;
    endfunction

    function automatic logic [0:511] rand_vec(input int log2n);
        logic [0:511] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        for (int i = 0; i < 512; i++) if (i >= (1 << log2n)) v[i] = 1'b0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present din at a negedge, wait for acceptance and then for out_valid (bounded).
    task automatic applyStimulus(input int k, input logic [0:511] din,
                                 output logic [0:511] got, output int lat);
        checkOutput("ready_before_accept", 512'(rdy[k]), 512'(1'b1));
        in_data[k]  = din;
        in_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 0;
        while (!vld[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = out_of(k);
    endtask

    task automatic release_result(input int k);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        checkOutput("ready_after_release", 512'(rdy[k]), 512'(1'b1));
        checkOutput("valid_after_release", 512'(vld[k]), 512'(1'b0));
    endtask

    vec_t         tbl [10];
    logic [0:511] got, exp_v;
    int           lat;

    initial begin
        logic [0:511] expq [$];
        int           acc_cyc [$];
        int           cyc, results;
        logic         took;

        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0;
        end

        tbl[0] = '{0, {8'h80, 504'b0}, {8'hFF, 504'b0}, 8};
        tbl[1] = '{0, {8'hFF, 504'b0}, {8'h80, 504'b0}, 1};
        tbl[2] = '{0, {8'h00, 504'b0}, {8'h00, 504'b0}, 0};
        tbl[3] = '{0, {8'h40, 504'b0}, {8'h55, 504'b0}, 4};
        tbl[4] = '{0, {8'h01, 504'b0}, {8'h01, 504'b0}, 1};
        for (int i = 0; i < 5; i++) begin
            tbl[i+5] = tbl[i];
            tbl[i+5].inst = 1;
        end

        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            checkOutput("reset_in_ready", 512'(rdy[k]), 512'(1'b1));
            checkOutput("reset_out_valid", 512'(vld[k]), 512'(1'b0));
            checkOutput("reset_out_data", out_of(k), 512'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] table vectors, LOG2_N=3");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tbl[i].inst, tbl[i].din, got, lat);
            checkOutput("table_data", got, tbl[i].dexp);
            checkOutput("table_latency", 512'(lat), 512'(log2n_of[tbl[i].inst] / rpc_of[tbl[i].inst]));
`ifdef MOBIUS_WEIGHT_EN
            checkOutput("table_weight", 512'(weight_of(tbl[i].inst)), 512'(tbl[i].wexp));
`endif
            release_result(tbl[i].inst);
        end

        $display("[TB] random vectors, LOG2_N=9");
        for (int k = 2; k < NI; k++) begin
            for (int r = 0; r < 3; r++) begin
                exp_v = rand_vec(9);
                applyStimulus(k, exp_v, got, lat);
                exp_v = mobius_ref(exp_v, 9);
                checkOutput("random_data", got, exp_v);
                checkOutput("random_latency", 512'(lat), 512'(9 / rpc_of[k]));
`ifdef MOBIUS_WEIGHT_EN
                checkOutput("random_weight", 512'(weight_of(k)), 512'($countones(exp_v)));
`endif
                release_result(k);
            end
        end

        $display("[TB] backpressure in HOLD");
        applyStimulus(0, {8'h40, 504'b0}, got, lat);
        for (int c = 0; c < 5; c++) begin
            in_valid[0] = c[0];
            in_data[0]  = {8'hA7, 504'b0};
            @(negedge clk);
            checkOutput("bp_data_stable", out_of(0), {8'h55, 504'b0});
            checkOutput("bp_in_ready_low", 512'(rdy[0]), 512'(1'b0));
            checkOutput("bp_out_valid_high", 512'(vld[0]), 512'(1'b1));
        end
        in_valid[0] = 1'b0;
        release_result(0);

        $display("[TB] reset during RUN");
        in_data[2]  = rand_vec(9);
        in_valid[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_in_ready", 512'(rdy[2]), 512'(1'b1));
        checkOutput("midrun_reset_out_valid", 512'(vld[2]), 512'(1'b0));
        checkOutput("midrun_reset_out_data", out_of(2), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_v = rand_vec(9);
        applyStimulus(2, exp_v, got, lat);
        checkOutput("post_reset_data", got, mobius_ref(exp_v, 9));
        checkOutput("post_reset_latency", 512'(lat), 512'(9));
        release_result(2);

        $display("[TB] back-to-back, LOG2_N=9 RPC=3");
        cyc = 0;
        results = 0;
        in_data[3]   = rand_vec(9);
        in_valid[3]  = 1'b1;
        out_ready[3] = 1'b1;
        while (results < 4 && cyc < 100) begin
            took = 1'b0;
            if (rdy[3]) begin
                expq.push_back(mobius_ref(in_data[3], 9));
                acc_cyc.push_back(cyc);
                took = 1'b1;
            end
            if (vld[3]) begin
                if (expq.size() == 0) begin
                    checkOutput("b2b_unexpected_result", 512'(1), 512'(0));
                end else begin
                    checkOutput("b2b_data", out_of(3), expq.pop_front());
                end
                results++;
                if (results == 4) in_valid[3] = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (took) in_data[3] = rand_vec(9);
        end
        out_ready[3] = 1'b0;
        checkOutput("b2b_results", 512'(results), 512'(4));
        checkOutput("b2b_accepts", 512'(acc_cyc.size()), 512'(4));
        for (int i = 1; i < acc_cyc.size(); i++)
            checkOutput("b2b_interval", 512'(acc_cyc[i] - acc_cyc[i-1]), 512'(9 / 3 + 2));
        @(negedge clk);
        checkOutput("b2b_idle_after", 512'(rdy[3]), 512'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mobius_engine.md
# mobius_engine

Parametrised, clocked binary Möbius transform (ANF ↔ truth table over GF(2)) of an N = 2^LOG2_N bit vector. It is the handshaked successor to the free-running single-round engine. It adds a valid/ready interface on both sides, a configurable number of butterfly-and-shuffle rounds per clock, and explicit completion signalling. It sits between a vector source (e.g. S-box or truth-table loader) and downstream ANF consumers.

## Interface
- LOG2_N, 9, log2 of vector length; N = 1<<LOG2_N derived (localparam); LOG2_N ≥ 1
- RPC, 1, rounds per cycle; 1 ≤ RPC ≤ LOG2_N and LOG2_N % RPC == 0, else elaboration error
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  source presents in_data
- in_ready  out  1  engine can accept; high only in IDLE
- in_data  in  [0:N-1]  input vector, index 0 first
- out_valid  out  1  out_data holds a finished transform
- out_ready  in  1  sink accepts result
- out_data  out  [0:N-1]  working register, always driven; meaningful only while out_valid
- out_weight  out  LOG2_N+1  popcount of out_data (MOBIUS_WEIGHT_EN only)

## Operation
- Round on x[0:N-1]: butterfly m[i]=x[i], m[i+N/2]=x[i+N/2]^x[i] for i<N/2; then shuffle y[2i]=m[i], y[2i+1]=m[i+N/2]. LOG2_N rounds = full transform. The transform is an involution, so the same block does forward and inverse.
- States:
  - IDLE: in_ready=1. On in_valid: load in_data, cnt←0 → RUN.
  - RUN: each cycle reg←RPC chained rounds of reg, cnt←cnt+RPC. When cnt+RPC==LOG2_N → HOLD.
  - HOLD: out_valid=1, reg frozen. On out_ready → IDLE.
- cnt width $clog2(LOG2_N+1); it never exceeds LOG2_N and does not wrap.
- One transform in flight. in_valid outside IDLE is ignored and does not stall or corrupt the engine.
- A HOLD→IDLE exit and a new acceptance never occur in the same cycle.
- Reset (any state, including mid-RUN): state=IDLE, reg=0, cnt=0, out_valid=0, in_ready=1 (combinational from state). No transfer occurs while rst_n is low. A partial result is discarded.

## Timing
- Input handshake at edge k. out_valid rises after edge k+LOG2_N/RPC. Default latency is 9 cycles.
- out_data and out_weight are stable for the whole time out_valid is high, whatever out_ready does.
- Result transfer is at the edge where out_valid && out_ready. in_ready rises the next cycle.
- Minimum initiation interval is LOG2_N/RPC+2 cycles, with out_ready held high.
- in_ready and out_valid are decoded directly from the state register. There is no combinational path from in_valid or out_ready to either output.

## Configuration
- MOBIUS_WEIGHT_EN defined:
  - out_weight port present.
  - It is the combinational popcount of out_data, valid while out_valid.
- MOBIUS_WEIGHT_EN undefined:
  - Port absent.
  - No popcount logic.
  - All other behaviour identical.

## Structure
- Package mobius_pkg holds:
  - state typedef (IDLE, RUN, HOLD), 2-bit encoding
  - function for counter width
  - weight-width helper
- Sub-module mobius_round:
  - #(N), pure combinational butterfly+shuffle.
  - RPC instances are chained by generate in mobius_engine.
- The engine holds the FSM, cnt, data register, handshakes and the optional popcount.

## Test plan
- LOG2_N=3, RPC=1, in_data[0]=1 and others 0 → after 3 cycles out_valid=1, out_data=all ones; out_weight=8 with the macro defined.
- Same config, feed the all-ones result back in → out_data[0]=1, others 0 (involution); all-zero input → all-zero output, weight 0.
- LOG2_N=3, RPC=3: out_valid one cycle after acceptance, same data as RPC=1. Random vectors for LOG2_N=9 with RPC∈{1,3,9} must match a software Möbius model.
- Backpressure: out_ready held low 5 cycles in HOLD → out_data stable, in_ready=0, in_valid pulses ignored. out_ready=1 → in_ready=1 the following cycle.
- Reset asserted mid-RUN (cnt=1) → out_valid=0, out_data=0, in_ready=1 immediately. A fresh transform after release gives the correct result.
- Back-to-back sources with in_valid held high and out_ready high → each transform accepted exactly once, interval LOG2_N/RPC+2 cycles.
